// File: rtl/register_file.sv
// register_file
//
// General-purpose register file for the single-cycle datapath. It sits
// directly after the write-back mux and feeds the decode/ALU operand path.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset; clears every register and
//               the write counter
//   RegWrite    write enable from control
//   WriteReg    destination register index
//   WriteBack   value to commit
//   ReadReg1/2  source register indices for the two operand ports
//   ReadData1/2 combinational operand values (index 0 always reads 0)
//   DbgAddr     inspection read index
//   DbgData     stored value at DbgAddr, never bypassed
//   WriteCount  committed writes since reset, saturating at 16'hFFFF
//
// Parameters:
//   DATA_WIDTH  register and data-port width
//   ADDR_WIDTH  register index width, NUM_REGS = 2**ADDR_WIDTH
//   BYPASS      1 = operand ports forward a write pending this cycle,
//               0 = operand ports return the stored value

module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteBack,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] DbgAddr,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic [15:0]           WriteCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en;
    logic                  fwd1;
    logic                  fwd2;

    // Writes aimed at r0 are dropped entirely, so they neither land in
    // storage nor count as committed.
    assign write_en = RegWrite && (WriteReg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[WriteReg] <= WriteBack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WriteCount <= '0;
        end else if (write_en && (WriteCount != 16'hFFFF)) begin
            WriteCount <= WriteCount + 16'd1;
        end
    end

    // Forwarding is qualified with rst_n so that every read port shows 0
    // while reset is held, even if control is still asserting a write.
    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
        if (BYPASS != 0) begin
            fwd1 = rst_n && write_en && (WriteReg == ReadReg1);
            fwd2 = rst_n && write_en && (WriteReg == ReadReg2);
        end
    end

    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end else if (fwd1) begin
            ReadData1 = WriteBack;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end else if (fwd2) begin
            ReadData2 = WriteBack;
        end
    end

    always_comb begin
        DbgData = regs[DbgAddr];
        if (DbgAddr == '0) begin
            DbgData = '0;
        end
    end

endmodule
